// File: rtl/spi_echo_slave_p.sv
// SPI slave that echoes each received word plus an increment as the next reply.
// Configurable width, SPI mode and bit order. Flags partial words when cs rises
// mid-word, counts complete words and drives a below-threshold LED.
module spi_echo_slave_p #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          CPOL       = 1'b0,
   parameter bit          CPHA       = 1'b0,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned INC        = 1,
   parameter logic [31:0] TX_INIT    = 32'h0000_00C3,
   parameter logic [31:0] LED_THRESH = 32'h0000_0080
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cs,
   input  logic             sck,
   input  logic             mosi,
   output logic             miso,
   output logic [WIDTH-1:0] rxd_out,
   output logic             rxd_flag,
   output logic             led_state,
   output logic             frame_err,
   output logic [15:0]      word_cnt
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [2:0]       cs_sr;
   logic [2:0]       sck_sr;
   logic [1:0]       mosi_sr;
   logic [WIDTH-1:0] tx_word;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-1:0] rx_shift;
   logic [CW-1:0]    bit_cnt;
   logic [CW-1:0]    tx_pos;

   logic             cs_fall_c, cs_rise_c;
   logic             sample_c, drive_c;
   logic             word_done_c;
   logic [WIDTH-1:0] rx_next_c;
   logic [WIDTH-1:0] tx_reply_c;
   logic [CW-1:0]    tx_idx_c;
   logic             drive_bit_c;
   logic             first_bit_c;

   // Synchronise async SPI inputs; cs flops reset low so a cs already low
   // after reset is never mistaken for a fresh frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sr   <= '0;
         sck_sr  <= {3{CPOL}};
         mosi_sr <= '0;
      end else begin
         cs_sr   <= {cs_sr[1:0], cs};
         sck_sr  <= {sck_sr[1:0], sck};
         mosi_sr <= {mosi_sr[0], mosi};
      end
   end

   // Edge classification, next receive word and outgoing bit selection.
   always_comb begin
      logic sck_rise, sck_fall, lead, trail;
      sck_rise    = sck_sr[1] & ~sck_sr[2];
      sck_fall    = ~sck_sr[1] & sck_sr[2];
      lead        = CPOL ? sck_fall : sck_rise;
      trail       = CPOL ? sck_rise : sck_fall;
      sample_c    = CPHA ? trail : lead;
      drive_c     = CPHA ? lead : trail;
      cs_fall_c   = ~cs_sr[1] & cs_sr[2];
      cs_rise_c   = cs_sr[1] & ~cs_sr[2];
      rx_next_c   = MSB_FIRST ? ((rx_shift << 1) | WIDTH'(mosi_sr[1]))
                              : ((rx_shift >> 1) | (WIDTH'(mosi_sr[1]) << (WIDTH - 1)));
      tx_reply_c  = rx_next_c + WIDTH'(INC);
      word_done_c = sample_c && (bit_cnt == CW'(WIDTH - 1));
      tx_idx_c    = MSB_FIRST ? (CW'(WIDTH - 1) - tx_pos) : tx_pos;
      drive_bit_c = |(tx_shift & (WIDTH'(1) << tx_idx_c));
      first_bit_c = |(tx_word & (MSB_FIRST ? (WIDTH'(1) << (WIDTH - 1)) : WIDTH'(1)));
   end

   // Frame FSM: shifting, word completion, reply reload and abort detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         miso      <= 1'b0;
         rxd_out   <= '0;
         rxd_flag  <= 1'b0;
         led_state <= 1'b0;
         frame_err <= 1'b0;
         word_cnt  <= '0;
         tx_word   <= WIDTH'(TX_INIT);
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         tx_pos    <= '0;
      end else begin
         rxd_flag  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               miso <= 1'b0;
               if (cs_fall_c) begin
                  state    <= SHIFT;
                  bit_cnt  <= '0;
                  tx_shift <= tx_word;
                  if (!CPHA) begin
                     miso   <= first_bit_c;
                     tx_pos <= CW'(1);
                  end else begin
                     tx_pos <= '0;
                  end
               end
            end
            SHIFT: begin
               if (sample_c) begin
                  rx_shift <= rx_next_c;
                  if (word_done_c) begin
                     rxd_out   <= rx_next_c;
                     rxd_flag  <= 1'b1;
                     word_cnt  <= word_cnt + 16'd1;
                     led_state <= (32'(rx_next_c) < LED_THRESH);
                     tx_word   <= tx_reply_c;
                     tx_shift  <= tx_reply_c;
                     tx_pos    <= '0;
                     bit_cnt   <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end else if (drive_c && (tx_pos < CW'(WIDTH))) begin
                  miso   <= drive_bit_c;
                  tx_pos <= tx_pos + CW'(1);
               end
               if (cs_rise_c) begin
                  state <= IDLE;
                  miso  <= 1'b0;
                  if (!word_done_c && ((bit_cnt != '0) || sample_c))
                     frame_err <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
